// File: rtl/div_stall_unit.sv
// Radix-2 restoring divider for DIV/DIVU in EX; raises a stall while busy.
// Optional macro DIV_CANCEL_EN lets a pipeline flush abort the divide.
module div_stall_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancelE,
  output logic             stalldivE,
  output logic             busyE,
  output logic             doneE,
  output logic [WIDTH-1:0] hidivE,
  output logic [WIDTH-1:0] lodivE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] rem, quo, dvs;
  logic [CW-1:0]    cnt;
  logic             sign_q, sign_r;

  logic             cancel;
`ifdef DIV_CANCEL_EN
  assign cancel = cancelE;
`else
  logic unused_cancel;
  assign unused_cancel = cancelE;
  assign cancel = 1'b0;
`endif

  logic             sign_a, sign_b, accept;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign sign_a = signedE & srcaE[WIDTH-1];
  assign sign_b = signedE & srcbE[WIDTH-1];
  assign mag_a  = sign_a ? -srcaE : srcaE;
  assign mag_b  = sign_b ? -srcbE : srcbE;
  assign accept = (state == IDLE) & startE & ~cancel;

  logic [WIDTH:0]   trial, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_step, quo_step;

  assign trial    = {rem, quo[WIDTH-1]};
  assign diff     = trial - {1'b0, dvs};
  assign ge       = trial >= {1'b0, dvs};
  assign rem_step = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_step = {quo[WIDTH-2:0], ge};

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state, stall and done decode
  always_comb begin
    state_n   = state;
    stalldivE = 1'b0;
    busyE     = (state != IDLE);
    doneE     = 1'b0;
    unique case (state)
      IDLE: begin
        stalldivE = startE & ~cancel;
        if (accept)
          state_n = (srcbE == '0) ? DONE : CALC;
      end
      CALC: begin
        stalldivE = ~cancel;
        if (cancel)
          state_n = IDLE;
        else if (cnt == LAST)
          state_n = DONE;
      end
      DONE: begin
        doneE   = ~cancel;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // operand latch, iteration datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hidivE <= '0;
      lodivE <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rem    <= '0;
            quo    <= mag_a;
            dvs    <= mag_b;
            cnt    <= '0;
            sign_q <= sign_a ^ sign_b;
            sign_r <= sign_a;
            if (srcbE == '0) begin
              lodivE <= '1;
              hidivE <= srcaE;
            end
          end
        end
        CALC: begin
          if (!cancel) begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              lodivE <= sign_q ? -quo_step : quo_step;
              hidivE <= sign_r ? -rem_step : rem_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
